seg_display_bank: RTL and testbench

Parametrised seven-segment display bank that generalises the per-digit HexDriver instances on the DE10-Lite HEX0..HEX5 outputs. It captures a WIDTH-bit value on a load strobe and renders it across DIGITS active-low digits in hex or decimal, with optional two's-complement sign and leading-zero blanking. Decimal rendering uses an iterative shift-add-3 (double-dabble) converter, so the block has a load/busy handshake. It sits in top_level between the SoC PIO/keycode sources and the HEXn pins.

---
 rtl/seg_display_bank_if.sv | 26 ++
 rtl/seg_display_bank.sv | 193 +++++++++++++++++++
 tb/tb_seg_display_bank.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_bank_if.sv
// Load/status bundle between a value source and the seven-segment display bank.
interface seg_display_bank_if #(
  parameter int DIGITS = 6,
  parameter int WIDTH  = 20
);
  // Handshake: the master may hold load high at any time. A load is accepted
  // at a rising edge only when busy is low at that edge; otherwise it is
  // dropped, not queued. busy stays high until the new image is on hex_out.
  logic                load;
  logic [WIDTH-1:0]    value;
  logic                is_signed;
  logic                dec_mode;
  logic                blank_lz;
  logic                busy;
  logic [8*DIGITS-1:0] hex_out;

  modport master (
    output load, value, is_signed, dec_mode, blank_lz,
    input  busy, hex_out
  );

  modport slave (
    input  load, value, is_signed, dec_mode, blank_lz,
    output busy, hex_out
  );
endinterface

// File: rtl/seg_display_bank.sv
// Seven-segment display bank: renders a captured value in hex or decimal with sign and blanking.
// SEG_DECIMAL_EN compiles in the iterative double-dabble converter and honours dec_mode.
module seg_display_bank #(
  parameter int DIGITS = 6,
  parameter int WIDTH  = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  seg_display_bank_if.slave bus,
  output logic [1:0]        state_o
);

  localparam int NB  = (WIDTH + 2) / 3;
  localparam int NH  = (WIDTH + 3) / 4;
  localparam int NN0 = (NB > NH) ? NB : NH;
  localparam int NN  = (NN0 > DIGITS) ? NN0 : DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                neg_q, neg_d;
  logic                blz_q, blz_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [8*DIGITS-1:0] hex_q, hex_d;

  logic [4*NN-1:0]     digit_vec;
  logic [3:0]          nib [NN];
  int                  msd;
  int                  avail;
  logic                ovf;
  logic [8*DIGITS-1:0] image;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

`ifdef SEG_DECIMAL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic            dec_q, dec_d;
  logic [4*NB-1:0] bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // One shift-add-3 step: correct every BCD digit >= 5, then shift in the next magnitude bit.
  function automatic logic [4*NB-1:0] dabble(input logic [4*NB-1:0] b, input logic bit_in);
    logic [4*NB-1:0] t;
    t = b;
    for (int j = 0; j < NB; j++) begin
      if (t[4*j +: 4] >= 4'd5) t[4*j +: 4] = t[4*j +: 4] + 4'd3;
    end
    return {t[4*NB-2:0], bit_in};
  endfunction

  assign digit_vec = dec_q ? (4*NN)'(bcd_q) : (4*NN)'(mag_q);
`else
  logic dec_mode_unused;
  assign dec_mode_unused = bus.dec_mode;
  assign digit_vec       = (4*NN)'(mag_q);
`endif

  always_comb begin
    for (int i = 0; i < NN; i++) nib[i] = digit_vec[4*i +: 4];
  end

  // Overflow, most significant nonzero digit and the rendered image.
  always_comb begin
    msd   = 0;
    ovf   = 1'b0;
    image = '1;
    avail = neg_q ? DIGITS - 1 : DIGITS;
    for (int i = 0; i < NN; i++) begin
      if (nib[i] != 4'h0) begin
        msd = i;
        if (i >= avail) ovf = 1'b1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf) begin
        image[8*i +: 8] = 8'hFE;
      end else if (blz_q) begin
        if (i <= msd)                   image[8*i +: 8] = glyph(nib[i]);
        else if (neg_q && i == msd + 1) image[8*i +: 8] = 8'hBF;
        else                            image[8*i +: 8] = 8'hFF;
      end else if (neg_q && i == DIGITS - 1) begin
        image[8*i +: 8] = 8'hBF;
      end else begin
        image[8*i +: 8] = glyph(nib[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    neg_d   = neg_q;
    blz_d   = blz_q;
    mag_d   = mag_q;
    hex_d   = hex_q;
`ifdef SEG_DECIMAL_EN
    dec_d   = dec_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          neg_d   = bus.is_signed && bus.value[WIDTH-1];
          mag_d   = neg_d ? WIDTH'(0 - bus.value) : bus.value;
          blz_d   = bus.blank_lz;
          busy_d  = 1'b1;
          state_d = S_UPDATE;
`ifdef SEG_DECIMAL_EN
          dec_d   = bus.dec_mode;
          bcd_d   = '0;
          cnt_d   = '0;
          if (bus.dec_mode) state_d = S_CONV;
`endif
        end
      end
      S_CONV: begin
`ifdef SEG_DECIMAL_EN
        bcd_d = dabble(bcd_q, mag_q[WIDTH-1]);
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_UPDATE;
`else
        state_d = S_UPDATE;
`endif
      end
      S_UPDATE: begin
        hex_d   = image;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      blz_q   <= 1'b0;
      mag_q   <= '0;
      hex_q   <= '1;
`ifdef SEG_DECIMAL_EN
      dec_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      neg_q   <= neg_d;
      blz_q   <= blz_d;
      mag_q   <= mag_d;
      hex_q   <= hex_d;
`ifdef SEG_DECIMAL_EN
      dec_q   <= dec_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.hex_out = hex_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_seg_display_bank.sv
// Self-checking bench for seg_display_bank: directed plan vectors plus random loads against a digit-arithmetic model.
module tb_seg_display_bank;
  localparam int D = 6;
  localparam int W = 20;
`ifdef SEG_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] state_dbg;

  seg_display_bank_if #(.DIGITS(D), .WIDTH(W)) bus ();

  seg_display_bank #(.DIGITS(D), .WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  always #5 Clk = ~Clk;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [8*D-1:0] exp_q[$];
  logic [8*D-1:0] shown;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference: split the magnitude into base-10/16 digits by division and apply the display rules.
  function automatic logic [8*D-1:0] model(input logic [W-1:0] v, input logic sg, input logic dc,
                                           input logic bz);
    logic            neg;
    logic [W-1:0]    mag;
    longint unsigned m, base;
    int              digs [16];
    int              nd, avail;
    logic [8*D-1:0]  img;
    neg  = sg && v[W-1];
    mag  = neg ? W'(0 - v) : v;
    base = (dc && DEC_EN) ? 64'd10 : 64'd16;
    m    = 64'(mag);
    nd   = 1;
    for (int i = 0; i < 16; i++) begin
      digs[i] = int'(m % base);
      m       = m / base;
      if (digs[i] != 0) nd = i + 1;
    end
    avail = neg ? D - 1 : D;
    if (nd > avail) return {D{8'hFE}};
    img = '1;
    for (int i = 0; i < D; i++) begin
      if (bz) begin
        if (i < nd)                img[8*i +: 8] = glyph_tab[digs[i]];
        else if (neg && i == nd)   img[8*i +: 8] = 8'hBF;
        else                       img[8*i +: 8] = 8'hFF;
      end else if (neg && i == D - 1) begin
        img[8*i +: 8] = 8'hBF;
      end else begin
        img[8*i +: 8] = glyph_tab[digs[i]];
      end
    end
    return img;
  endfunction

  // Called at a negedge; load is sampled at the next posedge. Optionally pokes a second
  // load at busy cycle poke_at, which must be dropped.
  task automatic drive_load(input logic [W-1:0] v, input logic sg, input logic dc, input logic bz,
                            input int poke_at, input logic [W-1:0] poke_v);
    logic [8*D-1:0] exp_img;
    int             lat;
    exp_q.push_back(model(v, sg, dc, bz));
    lat           = (dc && DEC_EN) ? W + 1 : 1;
    bus.value     = v;
    bus.is_signed = sg;
    bus.dec_mode  = dc;
    bus.blank_lz  = bz;
    bus.load      = 1'b1;
    @(negedge Clk);
    bus.load = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.hex_out !== shown) begin
        n_fail++;
        $display("FAIL busy_hold k=%0d v=%h: busy=%b hex=%h, required busy=1 hex=%h",
                 k, v, bus.busy, bus.hex_out, shown);
      end
      if (k == poke_at) begin
        bus.value     = poke_v;
        bus.is_signed = 1'($urandom_range(0, 1));
        bus.dec_mode  = 1'($urandom_range(0, 1));
        bus.blank_lz  = 1'($urandom_range(0, 1));
        bus.load      = 1'b1;
      end
      @(negedge Clk);
      bus.load = 1'b0;
    end
    exp_img = exp_q.pop_front();
    n_checks++;
    if (bus.hex_out !== exp_img || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL image v=%h sg=%b dc=%b bz=%b: hex=%h busy=%b, required hex=%h busy=0",
               v, sg, dc, bz, bus.hex_out, bus.busy, exp_img);
    end
    shown = exp_img;
  endtask

  task automatic test_reset();
    Reset         = 1'b1;
    bus.load      = 1'b0;
    bus.value     = '0;
    bus.is_signed = 1'b0;
    bus.dec_mode  = 1'b0;
    bus.blank_lz  = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (bus.hex_out !== {D{8'hFF}} || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: hex=%h busy=%b, required hex=%h busy=0", bus.hex_out, bus.busy,
               {D{8'hFF}});
    end
    Reset = 1'b0;
    shown = {D{8'hFF}};
    @(negedge Clk);
  endtask

  task automatic test_directed();
    drive_load(20'h0BEEF, 1'b0, 1'b0, 1'b1, 0, '0);
    drive_load(20'hFFB2E, 1'b1, 1'b1, 1'b1, 0, '0);
    drive_load(20'd999999, 1'b0, 1'b1, 1'b0, 0, '0);
    drive_load(20'd1000000 & 20'hFFFFF, 1'b0, 1'b1, 1'b0, 0, '0);
    drive_load(W'(0 - 100000), 1'b1, 1'b1, 1'b1, 0, '0);
    drive_load(20'h80000, 1'b1, 1'b0, 1'b0, 0, '0);
    drive_load(20'h00000, 1'b0, 1'b0, 1'b1, 0, '0);
    drive_load(20'h00000, 1'b1, 1'b1, 1'b1, 0, '0);
    drive_load(20'hFFFFF, 1'b1, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_load_while_busy();
    drive_load(20'd4321, 1'b0, 1'b1, 1'b1, 3, 20'd987);
    drive_load(20'd77, 1'b1, 1'b0, 1'b1, 0, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive_load(W'($urandom), 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) v = W'($urandom_range(0, 120));
      else                           v = W'($urandom);
      drive_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 6)), W'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    bus.value     = 20'd123456;
    bus.is_signed = 1'b0;
    bus.dec_mode  = 1'b1;
    bus.blank_lz  = 1'b0;
    bus.load      = 1'b1;
    @(negedge Clk);
    bus.load = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_checks++;
    if (bus.hex_out !== {D{8'hFF}} || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hex=%h busy=%b, required hex=%h busy=0", bus.hex_out, bus.busy,
               {D{8'hFF}});
    end
    shown = {D{8'hFF}};
    @(negedge Clk);
    n_checks++;
    if (bus.hex_out !== {D{8'hFF}} || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: hex=%h busy=%b, required hex=%h busy=0", bus.hex_out,
               bus.busy, {D{8'hFF}});
    end
    drive_load(20'd42, 1'b0, 1'b1, 1'b1, 0, '0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
